ibex_vector_conv_unit: RTL and testbench

//  Parametrised, pipelined N-tap convolution MAC for the vector pixel datapath.

---
 rtl/ibex_vconv_pkg.sv | 36 +++
 rtl/ibex_vconv_round_sat.sv | 46 ++++
 rtl/ibex_vector_conv_unit.sv | 187 ++++++++++++++++++
 tb/tb_ibex_vector_conv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_vconv_pkg.sv
// Shared types and kernel constants for the vector convolution unit.
package ibex_vconv_pkg;

    typedef enum logic [1:0] {
        VCONV_SUM    = 2'b00,
        VCONV_SINGLE = 2'b01,
        VCONV_PRESET = 2'b10
    } vconv_mode_e;

    // Tap that holds the non-zero coefficient of the reset (identity) kernel.
    localparam int unsigned VCONV_IDENT_TAP  = 32'd0;
    localparam int          VCONV_IDENT_COEF = 32'sd1;

    function automatic int vconv_sharpen(input int unsigned tap);
        int coef_v;
        if (tap == 32'd0) begin
            coef_v = 32'sd5;
        end else if (tap <= 32'd4) begin
            coef_v = -32'sd1;
        end else begin
            coef_v = 32'sd0;
        end
        return coef_v;
    endfunction

    function automatic int vconv_identity(input int unsigned tap);
        int coef_v;
        if (tap == VCONV_IDENT_TAP) begin
            coef_v = VCONV_IDENT_COEF;
        end else begin
            coef_v = 32'sd0;
        end
        return coef_v;
    endfunction

endpackage

// File: rtl/ibex_vconv_round_sat.sv
// Rounds, arithmetically shifts and clamps a signed convolution sum to an unsigned pixel.
module ibex_vconv_round_sat
    import ibex_vconv_pkg::*;
#(
    parameter int unsigned SumW   = 21,
    parameter int unsigned ShiftW = 4,
    parameter int unsigned OutW   = 8
) (
    input  logic signed [SumW-1:0]   sum_val,
    input  logic        [ShiftW-1:0] shift_amt,
    output logic        [OutW-1:0]   pix,
    output logic                     sat
);

    // One extra bit keeps the rounding increment from overflowing the sum.
    localparam int unsigned ExtW = SumW + 1;
    localparam logic signed [ExtW-1:0] MaxVal   = {{(ExtW-OutW){1'b0}}, {OutW{1'b1}}};
    localparam logic        [ExtW-1:0] ExtOne   = {{(ExtW-1){1'b0}}, 1'b1};
    localparam logic      [ShiftW-1:0] ShiftOne = {{(ShiftW-1){1'b0}}, 1'b1};

    logic signed [ExtW-1:0] ext_s;
    logic signed [ExtW-1:0] rnd_s;
    logic signed [ExtW-1:0] shr_s;

    // Round-half-up, shift, then clamp into the output pixel range.
    always_comb begin
        ext_s = {sum_val[SumW-1], sum_val};
        if (shift_amt != {ShiftW{1'b0}}) begin
            rnd_s = ext_s + (ExtOne << (shift_amt - ShiftOne));
        end else begin
            rnd_s = ext_s;
        end
        shr_s = rnd_s >>> shift_amt;
        if (shr_s[ExtW-1]) begin
            pix = {OutW{1'b0}};
            sat = 1'b1;
        end else if (shr_s > MaxVal) begin
            pix = {OutW{1'b1}};
            sat = 1'b1;
        end else begin
            pix = shr_s[OutW-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/ibex_vector_conv_unit.sv
// Three-stage N-tap convolution MAC: products, sum, round/shift/saturate.
module ibex_vector_conv_unit
    import ibex_vconv_pkg::*;
#(
    parameter int unsigned NumTaps = 9,
    parameter int unsigned PixW    = 8,
    parameter int unsigned CoefW   = 8,
    parameter int unsigned OutW    = 8,
    parameter int unsigned ShiftW  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [NumTaps*PixW-1:0]       in_pix_i,
    input  logic [1:0]                    mode_i,
    input  logic [$clog2(NumTaps)-1:0]    tap_sel_i,
    input  logic [ShiftW-1:0]             shift_i,
    input  logic                          coef_we_i,
    input  logic [$clog2(NumTaps)-1:0]    coef_idx_i,
    input  logic [CoefW-1:0]              coef_i,
    output logic                          coef_ready_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [OutW-1:0]               out_pix_o,
    output logic                          out_sat_o,
    output logic                          busy_o
);

    localparam int unsigned IdxW  = $clog2(NumTaps);
    localparam int unsigned ProdW = PixW + 1 + CoefW;
    localparam int unsigned SumW  = ProdW + $clog2(NumTaps);

    logic                    adv_s;
    logic                    busy_s;
    logic                    coef_rdy_s;
    logic                    coef_wr_s;
    vconv_mode_e             mode_in_s;

    logic signed [CoefW-1:0] coef_r     [NumTaps];
    logic signed [ProdW-1:0] prod_s     [NumTaps];

    logic                    s1_valid_r;
    logic signed [ProdW-1:0] prod_r     [NumTaps];
    vconv_mode_e             s1_mode_r;
    logic [IdxW-1:0]         s1_tap_sel_r;
    logic [ShiftW-1:0]       s1_shift_r;

    logic signed [SumW-1:0]  total_s;
    logic signed [SumW-1:0]  single_s;
    logic signed [SumW-1:0]  sum_s;

    logic                    s2_valid_r;
    logic signed [SumW-1:0]  s2_sum_r;
    logic [ShiftW-1:0]       s2_shift_r;

    logic                    out_valid_r;
    logic [OutW-1:0]         out_pix_r;
    logic                    out_sat_r;
    logic [OutW-1:0]         rs_pix_s;
    logic                    rs_sat_s;

    assign adv_s      = ~out_valid_r | out_ready_i;
    assign busy_s     = s1_valid_r | s2_valid_r | out_valid_r;
    assign coef_rdy_s = ~busy_s & ~in_valid_i;
    assign coef_wr_s  = coef_we_i & coef_rdy_s & (32'(coef_idx_i) < NumTaps);

    assign in_ready_o   = adv_s;
    assign coef_ready_o = coef_rdy_s;
    assign busy_o       = busy_s;
    assign out_valid_o  = out_valid_r;
    assign out_pix_o    = out_pix_r;
    assign out_sat_o    = out_sat_r;

    // Decode the raw mode; the unused encoding falls back to SUM.
    always_comb begin
        case (mode_i)
            2'b01:   mode_in_s = VCONV_SINGLE;
            2'b10:   mode_in_s = VCONV_PRESET;
            default: mode_in_s = VCONV_SUM;
        endcase
    end

    for (genvar k = 0; k < NumTaps; k++) begin : g_mul
        logic signed [CoefW-1:0] coef_use_s;
        logic signed [ProdW-1:0] pix_ext_s;
        logic signed [ProdW-1:0] coef_ext_s;

        assign coef_use_s = (mode_in_s == VCONV_PRESET) ? CoefW'(vconv_sharpen(k)) : coef_r[k];
        assign pix_ext_s  = {{(ProdW-PixW){1'b0}}, in_pix_i[k*PixW +: PixW]};
        assign coef_ext_s = {{(ProdW-CoefW){coef_use_s[CoefW-1]}}, coef_use_s};
        assign prod_s[k]  = pix_ext_s * coef_ext_s;
    end

    // S2 combinational: full-precision sum of all taps, or one selected tap.
    always_comb begin
        total_s = {SumW{1'b0}};
        for (int k = 0; k < NumTaps; k++) begin
            total_s = total_s + SumW'(prod_r[k]);
        end
        if (32'(s1_tap_sel_r) < NumTaps) begin
            single_s = SumW'(prod_r[s1_tap_sel_r]);
        end else begin
            single_s = {SumW{1'b0}};
        end
        case (s1_mode_r)
            VCONV_SINGLE: sum_s = single_s;
            default:      sum_s = total_s;
        endcase
    end

    ibex_vconv_round_sat #(
        .SumW   (SumW),
        .ShiftW (ShiftW),
        .OutW   (OutW)
    ) u_round_sat (
        .sum_val   (s2_sum_r),
        .shift_amt (s2_shift_r),
        .pix       (rs_pix_s),
        .sat       (rs_sat_s)
    );

    // Kernel register file; writes only land while the pipeline is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumTaps; k++) begin
                coef_r[k] <= CoefW'(vconv_identity(k));
            end
        end else if (coef_wr_s) begin
            coef_r[coef_idx_i] <= coef_i;
        end
    end

    // S1: capture products and per-beat controls on an accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r   <= 1'b0;
            s1_mode_r    <= VCONV_SUM;
            s1_tap_sel_r <= {IdxW{1'b0}};
            s1_shift_r   <= {ShiftW{1'b0}};
            for (int k = 0; k < NumTaps; k++) begin
                prod_r[k] <= {ProdW{1'b0}};
            end
        end else if (adv_s) begin
            s1_valid_r <= in_valid_i;
            if (in_valid_i) begin
                s1_mode_r    <= mode_in_s;
                s1_tap_sel_r <= tap_sel_i;
                s1_shift_r   <= shift_i;
                for (int k = 0; k < NumTaps; k++) begin
                    prod_r[k] <= prod_s[k];
                end
            end
        end
    end

    // S2: register the sum and the shift that travels with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {SumW{1'b0}};
            s2_shift_r <= {ShiftW{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sum_r   <= sum_s;
                s2_shift_r <= s1_shift_r;
            end
        end
    end

    // S3: registered, clamped result held stable while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_pix_r   <= {OutW{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_pix_r <= rs_pix_s;
                out_sat_r <= rs_sat_s;
            end
        end
    end

endmodule

// File: tb/tb_ibex_vector_conv_unit.sv
// Directed self-checking bench for ibex_vector_conv_unit with hand-computed results.
module tb_ibex_vector_conv_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_pix;
    logic [1:0]  mode;
    logic [3:0]  tap_sel;
    logic [3:0]  shift;
    logic        coef_we;
    logic [3:0]  coef_idx;
    logic [7:0]  coef;
    logic        coef_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic        out_sat;
    logic        busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    ibex_vector_conv_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_pix_i     (in_pix),
        .mode_i       (mode),
        .tap_sel_i    (tap_sel),
        .shift_i      (shift),
        .coef_we_i    (coef_we),
        .coef_idx_i   (coef_idx),
        .coef_i       (coef),
        .coef_ready_o (coef_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_pix_o    (out_pix),
        .out_sat_o    (out_sat),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pix_all(input logic [7:0] v);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    task automatic write_coef(input logic [3:0] idx, input logic [7:0] val);
        @(negedge clk);
        coef_we  = 1'b1;
        coef_idx = idx;
        coef     = val;
        #1;
        check_eq("coef_ready_idle", 32'(coef_ready), 32'd1);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic run_beat(input string tag, input logic [71:0] pix, input logic [1:0] md,
                            input logic [3:0] sel, input logic [3:0] sh,
                            input logic [7:0] exp_pix, input logic exp_sat, input logic try_we);
        int lat;
        @(negedge clk);
        in_pix    = pix;
        mode      = md;
        tap_sel   = sel;
        shift     = sh;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        if (try_we) begin
            coef_we  = 1'b1;
            coef_idx = 4'd0;
            coef     = 8'd100;
            #1;
            check_eq({tag, "_coef_ready"}, 32'(coef_ready), 32'd0);
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            coef_we  = 1'b0;
        end while (!out_valid && lat < 8);
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_pix"}, 32'(out_pix), 32'(exp_pix));
        check_eq({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    endtask

    initial begin
        logic [71:0] p;
        logic [7:0]  prev_pix;
        logic        prev_stall;
        logic        hs_in;
        int          sent;
        int          recv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pix    = 72'd0;
        mode      = 2'b00;
        tap_sel   = 4'd0;
        shift     = 4'd0;
        coef_we   = 1'b0;
        coef_idx  = 4'd0;
        coef      = 8'd0;
        out_ready = 1'b1;

        // 1: reset state, then identity kernel passes tap0 through
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pix", 32'(out_pix), 32'd0);
        check_eq("rst_out_sat", 32'(out_sat), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_coef_ready", 32'(coef_ready), 32'd1);
        run_beat("t1_ident", pix_all(8'd10), 2'b00, 4'd0, 4'd0, 8'd10, 1'b0, 1'b0);

        // 2: preset sharpen kernel clipping high and low
        p = 72'd0;
        p[7:0] = 8'd100;
        for (int k = 1; k < 5; k++) p[k*8 +: 8] = 8'd20;
        run_beat("t2_sharp_hi", p, 2'b10, 4'd0, 4'd0, 8'd255, 1'b1, 1'b0);
        p = pix_all(8'd50);
        p[7:0] = 8'd0;
        run_beat("t2_sharp_lo", p, 2'b10, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0);

        // 3: all-ones kernel with rounding shift; blocked write during a beat
        for (int k = 0; k < 9; k++) write_coef(4'(k), 8'd1);
        write_coef(4'd9, 8'd77);
        run_beat("t3_round", pix_all(8'd9), 2'b00, 4'd0, 4'd3, 8'd10, 1'b0, 1'b0);
        run_beat("t3_we_blk", pix_all(8'd9), 2'b00, 4'd0, 4'd3, 8'd10, 1'b0, 1'b1);
        run_beat("t3_kernel_kept", pix_all(8'd9), 2'b00, 4'd0, 4'd3, 8'd10, 1'b0, 1'b0);

        // 4: eight back-to-back beats with a 1,0,0,1 consumer pattern
        @(negedge clk);
        mode = 2'b00;
        shift = 4'd0;
        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        prev_pix = 8'd0;
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            if (cyc != 0) @(negedge clk);
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_pix = 72'd0;
                in_pix[7:0] = 8'(sent * 20 + 5);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check_eq("t4_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
                check_eq("t4_hold_pix", 32'(out_pix), 32'(prev_pix));
            end
            if (out_valid && out_ready) begin
                check_eq("t4_order_pix", 32'(out_pix), 32'(recv * 20 + 5));
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix = out_pix;
            hs_in = in_valid && in_ready;
            @(posedge clk);
            if (hs_in) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("t4_sent", 32'(sent), 32'd8);
        check_eq("t4_recv", 32'(recv), 32'd8);

        // 5: single-tap product, out-of-range tap, unused mode encoding
        write_coef(4'd3, 8'hFE);
        run_beat("t5_single_neg", pix_all(8'd7), 2'b01, 4'd3, 4'd0, 8'd0, 1'b1, 1'b0);
        run_beat("t5_single_oob", pix_all(8'd7), 2'b01, 4'd12, 4'd0, 8'd0, 1'b0, 1'b0);
        run_beat("t5_single_pos", pix_all(8'd200), 2'b01, 4'd0, 4'd0, 8'd200, 1'b0, 1'b0);
        run_beat("t5_mode3_sum", pix_all(8'd9), 2'b11, 4'd0, 4'd0, 8'd54, 1'b0, 1'b0);

        // 6: reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pix = pix_all(8'd10);
            mode = 2'b00;
            shift = 4'd0;
            out_ready = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        check_eq("t6_pre_busy", 32'(busy), 32'd1);
        check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_pix", 32'(out_pix), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_beat("t6_ident_again", pix_all(8'd10), 2'b00, 4'd0, 4'd0, 8'd10, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
